// File: rtl/tt_host_pkg.sv
// tt_host_pkg: shared types and constants for the tt_aiju host pin port.
//   state_t   - host port FSM states
//   bus_req_t - register-bus request driven by the port
//   cmd_ok()  - command byte reserved-field check
package tt_host_pkg;

  // Command byte layout: [7] write/read, [6:4] reserved (must be 0), [3:0] addr
  localparam int CMD_WR_BIT  = 7;
  localparam int CMD_RSV_MSB = 6;
  localparam int CMD_RSV_LSB = 4;
  localparam int ADDR_W      = 4;

  // Returned to the host when a read times out on the bus
  localparam logic [7:0] RD_ERR_VALUE = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMDACK,
    S_WDATA,
    S_BUS,
    S_ACK
  } state_t;

  typedef struct packed {
    logic              we;
    logic              re;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
  } bus_req_t;

  function automatic logic cmd_ok(input logic [7:0] b);
    return (b[CMD_RSV_MSB:CMD_RSV_LSB] == '0);
  endfunction

endpackage

// File: rtl/tt_sync.sv
// tt_sync: STAGES-deep flop synchronizer for asynchronous pin inputs.
//   clk, rst - clock, async active-high reset (flops clear to 0)
//   d        - asynchronous input
//   q        - synchronized output, STAGES clocks behind d
module tt_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pipe <= '0;
    else     pipe <= {pipe[STAGES-2:0], d};
  end

  assign q = pipe[STAGES-1];

endmodule

// File: rtl/tt_host_port.sv
// tt_host_port: pin-side host interface of the tt_aiju tile.
// The host places a byte on pin_data_in and toggles pin_stb; the port
// decodes register read/write commands, runs one transfer on the internal
// register bus and answers by toggling pin_ack (read data on pin_data_out).
//   clk, rst     - clock, async active-high reset
//   pin_data_in  - host byte, stable from strobe toggle until ack toggle
//   pin_stb      - async toggle strobe, one toggle per byte
//   pin_data_out - last read result (0xFF after a read timeout)
//   pin_ack      - toggles once per consumed byte
//   bus_*        - single-transfer register bus, request held until ready
//   err          - sticky bad-command / bus-timeout flag
module tt_host_port
  import tt_host_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pin_data_in,
  input  logic        pin_stb,
  output logic [7:0]  pin_data_out,
  output logic        pin_ack,
  output logic [3:0]  bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_we,
  output logic        bus_re,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_ready,
  output logic        err
);

  // Counter value on the TIMEOUT-th request cycle (counter starts at 0)
  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

  state_t     state;
  bus_req_t   req;
  logic [3:0] wait_cnt;
  logic       stb_sync;
  logic       stb_seen;
  logic       new_byte;

  tt_sync #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (1)
  ) u_stb_sync (
    .clk (clk),
    .rst (rst),
    .d   (pin_stb),
    .q   (stb_sync)
  );

  // stb_seen only advances when a byte is consumed, so a toggle that lands
  // while the port is busy stays pending here until the port can take it.
  assign new_byte = stb_sync ^ stb_seen;

  assign bus_addr  = req.addr;
  assign bus_wdata = req.wdata;
  assign bus_we    = req.we;
  assign bus_re    = req.re;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      req          <= '0;
      wait_cnt     <= '0;
      stb_seen     <= 1'b0;
      pin_ack      <= 1'b0;
      pin_data_out <= '0;
      err          <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (new_byte) begin
            stb_seen <= stb_sync;
            if (!cmd_ok(pin_data_in)) begin
              // Discard the byte but still acknowledge it
              err   <= 1'b1;
              state <= S_ACK;
            end else begin
              req.addr <= pin_data_in[ADDR_W-1:0];
              wait_cnt <= '0;
              if (pin_data_in[CMD_WR_BIT]) begin
                state <= S_CMDACK;
              end else begin
                req.re <= 1'b1;
                state  <= S_BUS;
              end
            end
          end
        end

        S_CMDACK: begin
          pin_ack <= ~pin_ack;
          state   <= S_WDATA;
        end

        S_WDATA: begin
          if (new_byte) begin
            stb_seen  <= stb_sync;
            req.wdata <= pin_data_in;
            req.we    <= 1'b1;
            wait_cnt  <= '0;
            state     <= S_BUS;
          end
        end

        S_BUS: begin
          // bus_ready wins over the timeout on the last allowed cycle
          if (bus_ready) begin
            if (req.re) pin_data_out <= bus_rdata;
            req.we <= 1'b0;
            req.re <= 1'b0;
            state  <= S_ACK;
          end else if (wait_cnt == WAIT_LAST) begin
            if (req.re) pin_data_out <= RD_ERR_VALUE;
            req.we <= 1'b0;
            req.re <= 1'b0;
            err    <= 1'b1;
            state  <= S_ACK;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end

        S_ACK: begin
          pin_ack <= ~pin_ack;
          state   <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_host_port.sv
module tb_tt_host_port;

  localparam int SYNC = 2;
  localparam int TO   = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pin_data_in;
  logic       pin_stb;
  logic [7:0] pin_data_out;
  logic       pin_ack;
  logic [3:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_we;
  logic       bus_re;
  logic [7:0] bus_rdata;
  logic       bus_ready;
  logic       err;

  tt_host_port #(.SYNC_STAGES(SYNC), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .pin_data_in  (pin_data_in),
    .pin_stb      (pin_stb),
    .pin_data_out (pin_data_out),
    .pin_ack      (pin_ack),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_we       (bus_we),
    .bus_re       (bus_re),
    .bus_rdata    (bus_rdata),
    .bus_ready    (bus_ready),
    .err          (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Register file on the bus side; answers after ready_delay wait cycles
  logic [7:0] bus_mem [16] = '{default: 8'h00};
  int ready_delay = 0;
  int req_age = 0;
  assign bus_ready = (bus_we | bus_re) && (req_age >= ready_delay);
  assign bus_rdata = bus_mem[bus_addr];
  always @(posedge clk) begin
    req_age <= (bus_we | bus_re) ? req_age + 1 : 0;
    if (bus_we && bus_ready) bus_mem[bus_addr] <= bus_wdata;
  end

  // Observation counters sampled on the falling edge
  int         ack_cnt = 0, we_total = 0, re_total = 0, wr_acc = 0;
  logic       prev_ack = 1'b0, both_hi = 1'b0;
  logic [7:0] prev_dout = 8'h00, dout_pre_ack = 8'h00, wr_data = 8'h00;
  logic [3:0] wr_addr = 4'h0;
  always @(negedge clk) begin
    if (pin_ack !== prev_ack) begin
      ack_cnt      <= ack_cnt + 1;
      dout_pre_ack <= prev_dout;
    end
    prev_ack  <= pin_ack;
    prev_dout <= pin_data_out;
    if (bus_we) we_total <= we_total + 1;
    if (bus_re) re_total <= re_total + 1;
    if (bus_we && bus_ready) begin
      wr_acc  <= wr_acc + 1;
      wr_addr <= bus_addr;
      wr_data <= bus_wdata;
    end
    if (bus_we && bus_re) both_hi <= 1'b1;
  end

  // Reference model: what the register file and host-visible pins should hold
  logic [7:0] exp_mem [16] = '{default: 8'h00};
  logic       err_exp  = 1'b0;
  logic [7:0] dout_exp = 8'h00;
  logic       stb_lvl  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    pin_data_in = b;
    stb_lvl     = ~stb_lvl;
    pin_stb     = stb_lvl;
  endtask

  task automatic wait_acks(input int target, output int lat);
    lat = 0;
    while (ack_cnt < target && lat < 100) begin
      tick();
      lat++;
    end
    if (ack_cnt < target) chk("ack_wait_expired", ack_cnt, target);
  endtask

  // Request cycles a transfer takes with ready after dl wait cycles
  function automatic int req_cycles(input int dl);
    return (dl + 1 < TO) ? dl + 1 : TO;
  endfunction

  task automatic do_write(input logic [3:0] a, input logic [7:0] d, input int dl, input string tag);
    int base, lat, we0, acc0, reqc;
    bit ok;
    ready_delay = dl;
    reqc = req_cycles(dl);
    ok   = (dl + 1 <= TO);
    base = ack_cnt;
    send({1'b1, 3'b000, a});
    wait_acks(base + 1, lat);
    chk({tag, " cmd_lat"}, lat, SYNC + 2);
    we0  = we_total;
    acc0 = wr_acc;
    send(d);
    wait_acks(base + 2, lat);
    chk({tag, " data_lat"}, lat, SYNC + 2 + reqc);
    chk({tag, " we_cycles"}, we_total - we0, reqc);
    if (ok) begin
      exp_mem[a] = d;
      chk({tag, " accepts"}, wr_acc - acc0, 1);
      chk({tag, " wr_addr"}, wr_addr, a);
      chk({tag, " wr_data"}, wr_data, d);
    end else begin
      err_exp = 1'b1;
      chk({tag, " accepts"}, wr_acc - acc0, 0);
    end
    chk({tag, " err"}, err, err_exp);
    chk({tag, " dout_held"}, pin_data_out, dout_exp);
  endtask

  task automatic do_read(input logic [3:0] a, input int dl, input string tag);
    int base, lat, re0, reqc;
    bit ok;
    ready_delay = dl;
    reqc = req_cycles(dl);
    ok   = (dl + 1 <= TO);
    base = ack_cnt;
    re0  = re_total;
    send({1'b0, 3'b000, a});
    wait_acks(base + 1, lat);
    dout_exp = ok ? exp_mem[a] : 8'hFF;
    if (!ok) err_exp = 1'b1;
    chk({tag, " lat"}, lat, SYNC + 2 + reqc);
    chk({tag, " re_cycles"}, re_total - re0, reqc);
    chk({tag, " dout"}, pin_data_out, dout_exp);
    chk({tag, " dout_pre_ack"}, dout_pre_ack, dout_exp);
    chk({tag, " err"}, err, err_exp);
  endtask

  task automatic do_bad(input logic [7:0] b, input string tag);
    int base, lat, we0, re0;
    base = ack_cnt;
    we0  = we_total;
    re0  = re_total;
    send(b);
    wait_acks(base + 1, lat);
    err_exp = 1'b1;
    chk({tag, " lat"}, lat, SYNC + 2);
    chk({tag, " no_req"}, (we_total - we0) + (re_total - re0), 0);
    chk({tag, " err"}, err, err_exp);
    chk({tag, " dout_held"}, pin_data_out, dout_exp);
  endtask

  initial begin
    int base, lat, acc0, re0, r, kind, dl;
    logic [3:0] a;
    logic [7:0] d;

    rst = 1'b1;
    pin_stb = 1'b0;
    pin_data_in = 8'h00;
    repeat (3) tick();
    chk("rst dout", pin_data_out, 8'h00);
    chk("rst ack", pin_ack, 1'b0);
    chk("rst addr", bus_addr, 4'h0);
    chk("rst wdata", bus_wdata, 8'h00);
    chk("rst we", bus_we, 1'b0);
    chk("rst re", bus_re, 1'b0);
    chk("rst err", err, 1'b0);
    rst = 1'b0;
    repeat (2) tick();

    // Basic write, ready tied high: ack goes 0->1->0
    do_write(4'h3, 8'h5A, 0, "wr83");
    chk("wr83 ack_level", pin_ack, 1'b0);
    chk("wr83 mem", bus_mem[3], 8'h5A);

    // Read with ready after 3 wait cycles
    do_write(4'h7, 8'hC3, 0, "wr87");
    do_read(4'h7, 3, "rd07");
    // Ready on the last allowed cycle still succeeds
    do_read(4'h3, TO - 1, "rd_edge");

    // Bad command, then next byte is a fresh command
    do_bad(8'h15, "bad15");
    do_write(4'h1, 8'h66, 0, "wr81");

    // Timeouts: read returns 0xFF, write is dropped, later write still works
    do_read(4'h2, 1000, "rd_to");
    do_write(4'h9, 8'hEE, TO, "wr_to");
    do_write(4'h4, 8'h11, 0, "wr_after_to");

    // Back-to-back: second toggle arrives while the read is on the bus
    ready_delay = 5;
    base = ack_cnt;
    re0  = re_total;
    send(8'h07);
    repeat (4) tick();
    chk("b2b busy_re", bus_re, 1'b1);
    send({1'b1, 3'b000, 4'hA});
    wait_acks(base + 2, lat);
    dout_exp = exp_mem[7];
    chk("b2b re_cycles", re_total - re0, req_cycles(5));
    chk("b2b dout", pin_data_out, dout_exp);
    ready_delay = 0;
    acc0 = wr_acc;
    send(8'h3C);
    wait_acks(base + 3, lat);
    exp_mem[4'hA] = 8'h3C;
    chk("b2b data_lat", lat, SYNC + 2 + 1);
    chk("b2b wr_addr", wr_addr, 4'hA);
    chk("b2b wr_data", wr_data, 8'h3C);
    repeat (3) tick();
    chk("b2b ack_total", ack_cnt - base, 3);
    chk("b2b accepts", wr_acc - acc0, 1);

    // Reset while a write request is waiting on the bus
    ready_delay = 1000;
    base = ack_cnt;
    send(8'h85);
    wait_acks(base + 1, lat);
    acc0 = wr_acc;
    send(8'h77);
    repeat (4) tick();
    chk("mid pre_we", bus_we, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid we", bus_we, 1'b0);
    chk("mid re", bus_re, 1'b0);
    chk("mid ack", pin_ack, 1'b0);
    chk("mid err", err, 1'b0);
    chk("mid dout", pin_data_out, 8'h00);
    chk("mid addr", bus_addr, 4'h0);
    chk("mid wdata", bus_wdata, 8'h00);
    stb_lvl = 1'b0;
    pin_stb = 1'b0;
    err_exp = 1'b0;
    dout_exp = 8'h00;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    chk("mid no_accept", wr_acc - acc0, 0);
    do_write(4'h5, 8'h77, 0, "post_rst_wr");
    do_read(4'h5, 1, "post_rst_rd");

    // Randomized command mix against the model
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 5);
      r    = $urandom_range(0, 9);
      dl   = (r < 7) ? r : (r == 7) ? TO - 1 : (r == 8) ? TO : 40;
      a    = 4'($urandom);
      d    = 8'($urandom);
      if (kind <= 2)      do_write(a, d, dl, $sformatf("rnd%0d wr", i));
      else if (kind <= 4) do_read(a, dl, $sformatf("rnd%0d rd", i));
      else                do_bad({d[7], 3'($urandom_range(1, 7)), a}, $sformatf("rnd%0d bad", i));
    end

    chk("we_re_exclusive", both_hi, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
